// File: rtl/lsu_pkg.sv
// Shared types for the byte-serial load/store unit.
// funct3 encodings, FSM states and beat-count helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;
    localparam logic [2:0] F3_XX = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_e;

    // Access size in bytes: 1, 2, 4 or 8, from the low two funct3 bits.
    function automatic logic [3:0] beat_count(input logic [2:0] f3);
        return 4'd1 << f3[1:0];
    endfunction

    function automatic logic f3_illegal(input logic store,
                                        input logic [2:0] f3);
        return store ? f3[2] : (f3 == F3_XX);
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of assembled load data to 64 bits.
// Pure combinational; ld passes through unchanged.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [63:0] i_raw,
    input  logic [2:0]  i_funct3,
    output logic [63:0] o_ext
);

    always_comb begin
        o_ext = i_raw;
        case (i_funct3)
            F3_B:    o_ext = {{56{i_raw[7]}},  i_raw[7:0]};
            F3_H:    o_ext = {{48{i_raw[15]}}, i_raw[15:0]};
            F3_W:    o_ext = {{32{i_raw[31]}}, i_raw[31:0]};
            F3_BU:   o_ext = {56'd0, i_raw[7:0]};
            F3_HU:   o_ext = {48'd0, i_raw[15:0]};
            F3_WU:   o_ext = {32'd0, i_raw[31:0]};
            default: o_ext = i_raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-serial RV64 load/store initiator, little-endian.
// Define MISALIGN_TRAP_EN to reject accesses not aligned to their size.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_store,
    input  logic [2:0]    req_funct3,
    input  logic [63:0]   req_addr,
    input  logic [63:0]   req_wdata,
    output logic          resp_valid,
    output logic [63:0]   resp_data,
    output logic          resp_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    state_e        r_state;
    logic [2:0]    r_cnt;
    logic [AW-1:0] r_base;
    logic [63:0]   r_wdata;
    logic [2:0]    r_f3;
    logic          r_store;
    logic [63:0]   r_data;

    logic          r_req_ready;
    logic          r_resp_valid;
    logic          r_resp_err;
    logic          r_mem_re;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [7:0]    r_mem_wdata;

    logic          w_req_bad;
    logic          w_req_mis;
    logic          w_req_err;
    logic [3:0]    w_nbytes;
    logic          w_last;
    logic [2:0]    w_next_cnt;
    logic [63:0]   w_ext;
    logic          w_unused;

    assign w_unused  = ^req_addr[63:AW];
    assign w_req_bad = f3_illegal(req_store, req_funct3);

`ifdef MISALIGN_TRAP_EN
    logic [2:0] w_req_mask;
    assign w_req_mask = 3'(beat_count(req_funct3) - 4'd1);
    assign w_req_mis  = |(req_addr[2:0] & w_req_mask);
`else
    assign w_req_mis  = 1'b0;
`endif

    assign w_req_err  = w_req_bad | w_req_mis;
    assign w_nbytes   = beat_count(r_f3);
    assign w_last     = ({1'b0, r_cnt} == (w_nbytes - 4'd1));
    assign w_next_cnt = r_cnt + 3'd1;

    lsu_extend u_extend (
        .i_raw    (r_data),
        .i_funct3 (r_f3),
        .o_ext    (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_base       <= '0;
            r_wdata      <= '0;
            r_f3         <= '0;
            r_store      <= 1'b0;
            r_data       <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_base      <= req_addr[AW-1:0];
                        r_wdata     <= req_wdata;
                        r_f3        <= req_funct3;
                        r_store     <= req_store;
                        r_cnt       <= '0;
                        r_data      <= '0;
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state     <= XFER;
                            r_mem_re    <= !req_store;
                            r_mem_we    <= req_store;
                            r_mem_addr  <= req_addr[AW-1:0];
                            r_mem_wdata <= req_wdata[7:0];
                        end
                    end
                end
                XFER: begin
                    if (!r_store) begin
                        r_data[8*r_cnt +: 8] <= mem_rdata;
                    end
                    if (w_last) begin
                        r_state      <= RESP;
                        r_mem_re     <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_mem_addr   <= '0;
                        r_mem_wdata  <= '0;
                        r_resp_valid <= 1'b1;
                    end else begin
                        // Address wraps modulo 2^AW by truncation.
                        r_cnt       <= w_next_cnt;
                        r_mem_addr  <= r_base + AW'(w_next_cnt);
                        r_mem_wdata <= r_wdata[8*w_next_cnt +: 8];
                    end
                end
                RESP: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_req_ready  <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign mem_re     = r_mem_re;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign resp_data  = (r_resp_valid && !r_store && !r_resp_err)
                        ? w_ext : 64'd0;

endmodule
